// File: rtl/scmp_useq_pkg.sv
// scmp_microcode_pak: shared microcode definitions for the SC/MP core.
//   NXT_t    - next-address type field of the control word
//   COND_t   - condition select field of the control word
//   NEXTPC_t - micro-PC label type, with the FETCH (reset) and IRQ labels
// Encodings that do not appear in NXT_t or COND_t are still legal on the wire.
// The sequencer treats an unknown NXT_t as SEQ and an unknown COND_t as false.
package scmp_microcode_pak;

    localparam int UC_UPC_W = 8;

    typedef logic [UC_UPC_W-1:0] NEXTPC_t;

    localparam NEXTPC_t L_FETCH = 8'h00;
    localparam NEXTPC_t L_IRQ   = 8'hF0;

    typedef enum logic [2:0] {
        NXT_SEQ  = 3'd0,
        NXT_JMP  = 3'd1,
        NXT_DISP = 3'd2,
        NXT_COND = 3'd3,
        NXT_HALT = 3'd4,
        NXT_CALL = 3'd5,
        NXT_RET  = 3'd6
    } NXT_t;

    typedef enum logic [2:0] {
        COND_TRUE = 3'd0,
        COND_Z    = 3'd1,
        COND_NZ   = 3'd2,
        COND_NEG  = 3'd3,
        COND_CY   = 3'd4,
        COND_CTRZ = 3'd5
    } COND_t;

endpackage

// File: rtl/scmp_useq_if.sv
// scmp_useq_if: bundle between the microcode sequencer and its surroundings
// (opcode decoder, microcode ROM word, ALU flags, bus handshake, counter control).
//   master : drives decoder/ROM/flag/bus inputs, observes upc and status
//   slave  : the sequencer itself
interface scmp_useq_if #(
    parameter int UPC_W = 8,
    parameter int CTR_W = 16
);
    logic [UPC_W-1:0] op_pc;
    logic [2:0]       uc_nxt;
    logic [UPC_W-1:0] uc_tgt;
    logic [2:0]       uc_cond;
    logic             uc_wait;
    logic             bus_rdy;
    logic             acc_z;
    logic             acc_neg;
    logic             cy;
    logic             ie;
    logic             sense_a;
    logic             cont;
    logic             ctr_ld;
    logic             ctr_dec;
    logic [CTR_W-1:0] ctr_din;
    logic [UPC_W-1:0] upc;
    logic             halted;
    logic             irq_take;
    logic             ctr_zero;

    modport master (
        output op_pc, uc_nxt, uc_tgt, uc_cond, uc_wait, bus_rdy,
               acc_z, acc_neg, cy, ie, sense_a, cont,
               ctr_ld, ctr_dec, ctr_din,
        input  upc, halted, irq_take, ctr_zero
    );

    modport slave (
        input  op_pc, uc_nxt, uc_tgt, uc_cond, uc_wait, bus_rdy,
               acc_z, acc_neg, cy, ie, sense_a, cont,
               ctr_ld, ctr_dec, ctr_din,
        output upc, halted, irq_take, ctr_zero
    );
endinterface

// File: rtl/scmp_useq_cond.sv
// scmp_useq_cond: combinational condition mux for COND micro-branches.
//   uc_cond   in  condition select (COND_t)
//   acc_z     in  accumulator == 0
//   acc_neg   in  accumulator bit 7
//   cy        in  carry/link
//   ctr_zero  in  loop counter == 0 (current, pre-update value)
//   cond_true out selected condition holds; unknown selects give 0
module scmp_useq_cond
    import scmp_microcode_pak::*;
(
    input  logic [2:0] uc_cond,
    input  logic       acc_z,
    input  logic       acc_neg,
    input  logic       cy,
    input  logic       ctr_zero,
    output logic       cond_true
);

    always_comb begin
        cond_true = 1'b0;
        case (uc_cond)
            COND_TRUE: cond_true = 1'b1;
            COND_Z:    cond_true = acc_z;
            COND_NZ:   cond_true = ~acc_z;
            COND_NEG:  cond_true = acc_neg;
            COND_CY:   cond_true = cy;
            COND_CTRZ: cond_true = ctr_zero;
            default:   cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/scmp_useq.sv
// scmp_useq: microcode sequencer for the SC/MP core. Owns the micro-PC, the
// RUN/HALT state, the loop/delay counter and interrupt entry at dispatch.
//   clk, rst  core clock; asynchronous active-high reset
//   bus       scmp_useq_if.slave: control word (uc_*), op_pc, flags, ie,
//             sense_a, cont, bus_rdy, counter controls in; upc, halted,
//             irq_take, ctr_zero out
// Optional build macro SCMP_USEQ_CALL_EN: adds a one-entry return register
// for CALL/RET. Without it CALL acts as JMP and RET returns to RESET_PC.
module scmp_useq
    import scmp_microcode_pak::*;
#(
    parameter int               UPC_W    = UC_UPC_W,
    parameter int               CTR_W    = 16,
    parameter logic [UPC_W-1:0] RESET_PC = L_FETCH,
    parameter logic [UPC_W-1:0] IRQ_PC   = L_IRQ
) (
    input logic        clk,
    input logic        rst,
    scmp_useq_if.slave bus
);

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [UPC_W-1:0] upc_r, upc_nxt, upc_inc;
    logic [CTR_W-1:0] ctr, ctr_nxt;
    logic             irq_r, irq_nxt;
    logic             ctr_zero;
    logic             cond_true;
    logic             stall;
`ifdef SCMP_USEQ_CALL_EN
    logic [UPC_W-1:0] ret, ret_nxt;
`endif

    assign stall    = bus.uc_wait & ~bus.bus_rdy;
    assign upc_inc  = upc_r + UPC_W'(1);
    assign ctr_zero = (ctr == '0);

    scmp_useq_cond u_cond (
        .uc_cond   (bus.uc_cond),
        .acc_z     (bus.acc_z),
        .acc_neg   (bus.acc_neg),
        .cy        (bus.cy),
        .ctr_zero  (ctr_zero),
        .cond_true (cond_true)
    );

    always_comb begin
        state_nxt = state;
        upc_nxt   = upc_r;
        ctr_nxt   = ctr;
        irq_nxt   = 1'b0;
`ifdef SCMP_USEQ_CALL_EN
        ret_nxt   = ret;
`endif
        case (state)
            ST_RUN: begin
                if (!stall) begin
                    case (bus.uc_nxt)
                        NXT_JMP:  upc_nxt = bus.uc_tgt;
                        NXT_COND: upc_nxt = cond_true ? bus.uc_tgt : upc_inc;
                        NXT_DISP: begin
                            if (bus.sense_a && bus.ie) begin
                                upc_nxt = IRQ_PC;
                                irq_nxt = 1'b1;
                            end else begin
                                upc_nxt = bus.op_pc;
                            end
                        end
                        // Advance past the HALT word now so that resuming
                        // needs no extra increment.
                        NXT_HALT: begin
                            upc_nxt   = upc_inc;
                            state_nxt = ST_HALT;
                        end
`ifdef SCMP_USEQ_CALL_EN
                        NXT_CALL: begin
                            ret_nxt = upc_inc;
                            upc_nxt = bus.uc_tgt;
                        end
                        NXT_RET:  upc_nxt = ret;
`else
                        NXT_CALL: upc_nxt = bus.uc_tgt;
                        NXT_RET:  upc_nxt = RESET_PC;
`endif
                        default:  upc_nxt = upc_inc;
                    endcase

                    // Load has priority; decrement saturates at zero.
                    if (bus.ctr_ld) begin
                        ctr_nxt = bus.ctr_din;
                    end else if (bus.ctr_dec && !ctr_zero) begin
                        ctr_nxt = ctr - CTR_W'(1);
                    end
                end
            end
            ST_HALT: begin
                if (bus.cont) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            upc_r <= RESET_PC;
            ctr   <= '0;
            irq_r <= 1'b0;
`ifdef SCMP_USEQ_CALL_EN
            ret   <= RESET_PC;
`endif
        end else begin
            state <= state_nxt;
            upc_r <= upc_nxt;
            ctr   <= ctr_nxt;
            irq_r <= irq_nxt;
`ifdef SCMP_USEQ_CALL_EN
            ret   <= ret_nxt;
`endif
        end
    end

    assign bus.upc      = upc_r;
    assign bus.halted   = (state == ST_HALT);
    assign bus.irq_take = irq_r;
    assign bus.ctr_zero = ctr_zero;

endmodule

// File: tb/tb_scmp_useq.sv
// tb_scmp_useq: self-checking bench for scmp_useq. Each scenario is a table of
// clock steps (control word + side inputs + expected outputs after the edge).
// Expected entries are queued when a step is driven and popped after the edge.
module tb_scmp_useq;
    import scmp_microcode_pak::*;

    // misc input bits: {sense_a, ie, cont, acc_z, acc_neg, cy}
    localparam logic [5:0] M_SA   = 6'b100000;
    localparam logic [5:0] M_IE   = 6'b010000;
    localparam logic [5:0] M_CONT = 6'b001000;
    localparam logic [5:0] M_Z    = 6'b000100;
    localparam logic [5:0] M_NEG  = 6'b000010;
    localparam logic [5:0] M_CY   = 6'b000001;
    // expected flag bits: {halted, irq_take, ctr_zero}
    localparam logic [2:0] E_H    = 3'b100;
    localparam logic [2:0] E_IRQ  = 3'b010;
    localparam logic [2:0] E_CZ   = 3'b001;

    typedef struct {
        string       nm;
        logic [2:0]  nxt;
        logic [7:0]  tgt;
        logic [2:0]  cond;
        logic        wt;
        logic        rdy;
        logic        ld;
        logic        dec;
        logic [15:0] din;
        logic [7:0]  op;
        logic [5:0]  misc;
        logic [7:0]  e_upc;
        logic [2:0]  e_flg;
    } step_t;

    logic  clk;
    logic  rst;
    int    checks = 0;
    int    errors = 0;
    step_t sb[$];

    scmp_useq_if #(.UPC_W(8), .CTR_W(16)) bus ();

    scmp_useq #(
        .UPC_W    (8),
        .CTR_W    (16),
        .RESET_PC (8'h00),
        .IRQ_PC   (8'hF0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive(input step_t s);
        bus.uc_nxt  = s.nxt;
        bus.uc_tgt  = s.tgt;
        bus.uc_cond = s.cond;
        bus.uc_wait = s.wt;
        bus.bus_rdy = s.rdy;
        bus.ctr_ld  = s.ld;
        bus.ctr_dec = s.dec;
        bus.ctr_din = s.din;
        bus.op_pc   = s.op;
        {bus.sense_a, bus.ie, bus.cont, bus.acc_z, bus.acc_neg, bus.cy} = s.misc;
    endtask

    task automatic test_reset();
        step_t st[$];
        step_t e;
        rst = 1'b1;
        drive('{"idle", NXT_SEQ, 8'h00, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, 6'b0, 8'h00, E_CZ});
        #2;
        sb.push_back('{"reset_state", NXT_SEQ, 8'h00, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, 6'b0, 8'h00, E_CZ});
        e = sb.pop_front();
        checks++;
        if ({bus.upc, bus.halted, bus.irq_take, bus.ctr_zero} !== {e.e_upc, e.e_flg}) begin
            errors++;
            $display("FAIL %s: got upc=%h h/irq/cz=%b, want upc=%h h/irq/cz=%b",
                     e.nm, bus.upc, {bus.halted, bus.irq_take, bus.ctr_zero}, e.e_upc, e.e_flg);
        end
        #5 rst = 1'b0;

        st.push_back('{"rst_jmp37",   NXT_JMP, 8'h37, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, 6'b0, 8'h37, E_CZ});
        st.push_back('{"rst_stall37", NXT_SEQ, 8'h00, COND_TRUE, 1, 0, 1, 0, 16'h5, 8'h00, 6'b0, 8'h37, E_CZ});
        foreach (st[i]) begin
            drive(st[i]);
            sb.push_back(st[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({bus.upc, bus.halted, bus.irq_take, bus.ctr_zero} !== {e.e_upc, e.e_flg}) begin
                errors++;
                $display("FAIL %s: got upc=%h h/irq/cz=%b, want upc=%h h/irq/cz=%b",
                         e.nm, bus.upc, {bus.halted, bus.irq_take, bus.ctr_zero}, e.e_upc, e.e_flg);
            end
        end

        // Still stalled at 8'h37: reset lands between clock edges.
        #3 rst = 1'b1;
        #1;
        sb.push_back('{"rst_midstall", NXT_SEQ, 8'h00, COND_TRUE, 1, 0, 0, 0, 16'h0, 8'h00, 6'b0, 8'h00, E_CZ});
        e = sb.pop_front();
        checks++;
        if ({bus.upc, bus.halted, bus.irq_take, bus.ctr_zero} !== {e.e_upc, e.e_flg}) begin
            errors++;
            $display("FAIL %s: got upc=%h h/irq/cz=%b, want upc=%h h/irq/cz=%b",
                     e.nm, bus.upc, {bus.halted, bus.irq_take, bus.ctr_zero}, e.e_upc, e.e_flg);
        end
        #2 rst = 1'b0;
        drive('{"idle", NXT_SEQ, 8'h00, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, 6'b0, 8'h00, E_CZ});
    endtask

    task automatic test_dispatch();
        step_t st[$];
        step_t e;
        st.push_back('{"disp_op",      NXT_DISP, 8'h00, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h40, M_IE,        8'h40, E_CZ});
        st.push_back('{"disp_irq",     NXT_DISP, 8'h00, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h40, M_SA | M_IE, 8'hF0, E_IRQ | E_CZ});
        st.push_back('{"irq_pulse1",   NXT_SEQ,  8'h00, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h40, M_SA | M_IE, 8'hF1, E_CZ});
        st.push_back('{"disp_ie0",     NXT_DISP, 8'h00, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h40, M_SA,        8'h40, E_CZ});
        st.push_back('{"disp_stall",   NXT_DISP, 8'h00, COND_TRUE, 1, 0, 0, 0, 16'h0, 8'h55, M_SA | M_IE, 8'h40, E_CZ});
        st.push_back('{"disp_rdy_irq", NXT_DISP, 8'h00, COND_TRUE, 1, 1, 0, 0, 16'h0, 8'h55, M_SA | M_IE, 8'hF0, E_IRQ | E_CZ});
        st.push_back('{"disp_op55",    NXT_DISP, 8'h00, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h55, 6'b0,        8'h55, E_CZ});
        foreach (st[i]) begin
            drive(st[i]);
            sb.push_back(st[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({bus.upc, bus.halted, bus.irq_take, bus.ctr_zero} !== {e.e_upc, e.e_flg}) begin
                errors++;
                $display("FAIL %s: got upc=%h h/irq/cz=%b, want upc=%h h/irq/cz=%b",
                         e.nm, bus.upc, {bus.halted, bus.irq_take, bus.ctr_zero}, e.e_upc, e.e_flg);
            end
        end
    endtask

    task automatic test_stall();
        step_t st[$];
        step_t e;
        st.push_back('{"stl_jmp10", NXT_JMP, 8'h10, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, 6'b0, 8'h10, E_CZ});
        for (int k = 0; k < 3; k++)
            st.push_back('{"stl_hold", NXT_SEQ, 8'h00, COND_TRUE, 1, 0, 1, 0, 16'h7, 8'h00, 6'b0, 8'h10, E_CZ});
        st.push_back('{"stl_release", NXT_SEQ, 8'h00, COND_TRUE, 1, 1, 0, 0, 16'h0, 8'h00, 6'b0, 8'h11, E_CZ});
        st.push_back('{"stl_nowait",  NXT_SEQ, 8'h00, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, 6'b0, 8'h12, E_CZ});
        foreach (st[i]) begin
            drive(st[i]);
            sb.push_back(st[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({bus.upc, bus.halted, bus.irq_take, bus.ctr_zero} !== {e.e_upc, e.e_flg}) begin
                errors++;
                $display("FAIL %s: got upc=%h h/irq/cz=%b, want upc=%h h/irq/cz=%b",
                         e.nm, bus.upc, {bus.halted, bus.irq_take, bus.ctr_zero}, e.e_upc, e.e_flg);
            end
        end
    endtask

    task automatic test_counter();
        step_t st[$];
        step_t e;
        st.push_back('{"ctr_jmp18",  NXT_JMP,  8'h18, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, 6'b0, 8'h18, E_CZ});
        st.push_back('{"ctr_ld3",    NXT_SEQ,  8'h00, COND_TRUE, 0, 0, 1, 0, 16'h3, 8'h00, 6'b0, 8'h19, 3'b000});
        st.push_back('{"ctr_pass1",  NXT_COND, 8'h20, COND_CTRZ, 0, 0, 0, 1, 16'h0, 8'h00, 6'b0, 8'h1A, 3'b000});
        st.push_back('{"ctr_pass2",  NXT_COND, 8'h20, COND_CTRZ, 0, 0, 0, 1, 16'h0, 8'h00, 6'b0, 8'h1B, 3'b000});
        st.push_back('{"ctr_pass3",  NXT_COND, 8'h20, COND_CTRZ, 0, 0, 0, 1, 16'h0, 8'h00, 6'b0, 8'h1C, E_CZ});
        st.push_back('{"ctr_pass4",  NXT_COND, 8'h20, COND_CTRZ, 0, 0, 0, 1, 16'h0, 8'h00, 6'b0, 8'h20, E_CZ});
        st.push_back('{"ctr_sat0",   NXT_SEQ,  8'h00, COND_TRUE, 0, 0, 0, 1, 16'h0, 8'h00, 6'b0, 8'h21, E_CZ});
        st.push_back('{"ctr_ld_pri", NXT_SEQ,  8'h00, COND_TRUE, 0, 0, 1, 1, 16'h2, 8'h00, 6'b0, 8'h22, 3'b000});
        st.push_back('{"ctr_dec2",   NXT_COND, 8'h30, COND_CTRZ, 0, 0, 0, 1, 16'h0, 8'h00, 6'b0, 8'h23, 3'b000});
        st.push_back('{"ctr_dec1",   NXT_SEQ,  8'h00, COND_TRUE, 0, 0, 0, 1, 16'h0, 8'h00, 6'b0, 8'h24, E_CZ});
        foreach (st[i]) begin
            drive(st[i]);
            sb.push_back(st[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({bus.upc, bus.halted, bus.irq_take, bus.ctr_zero} !== {e.e_upc, e.e_flg}) begin
                errors++;
                $display("FAIL %s: got upc=%h h/irq/cz=%b, want upc=%h h/irq/cz=%b",
                         e.nm, bus.upc, {bus.halted, bus.irq_take, bus.ctr_zero}, e.e_upc, e.e_flg);
            end
        end
    endtask

    task automatic test_cond();
        step_t st[$];
        step_t e;
        st.push_back('{"c_z_t",    NXT_COND, 8'h40, COND_Z,    0, 0, 0, 0, 16'h0, 8'h00, M_Z,   8'h40, E_CZ});
        st.push_back('{"c_z_f",    NXT_COND, 8'h50, COND_Z,    0, 0, 0, 0, 16'h0, 8'h00, 6'b0,  8'h41, E_CZ});
        st.push_back('{"c_nz_t",   NXT_COND, 8'h50, COND_NZ,   0, 0, 0, 0, 16'h0, 8'h00, 6'b0,  8'h50, E_CZ});
        st.push_back('{"c_nz_f",   NXT_COND, 8'h60, COND_NZ,   0, 0, 0, 0, 16'h0, 8'h00, M_Z,   8'h51, E_CZ});
        st.push_back('{"c_neg_t",  NXT_COND, 8'h60, COND_NEG,  0, 0, 0, 0, 16'h0, 8'h00, M_NEG, 8'h60, E_CZ});
        st.push_back('{"c_cy_t",   NXT_COND, 8'h70, COND_CY,   0, 0, 0, 0, 16'h0, 8'h00, M_CY,  8'h70, E_CZ});
        st.push_back('{"c_cy_f",   NXT_COND, 8'h7F, COND_CY,   0, 0, 0, 0, 16'h0, 8'h00, 6'b0,  8'h71, E_CZ});
        st.push_back('{"c_true",   NXT_COND, 8'h7F, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, 6'b0,  8'h7F, E_CZ});
        st.push_back('{"c_undef6", NXT_COND, 8'h90, 3'd6, 0, 0, 0, 0, 16'h0, 8'h00, M_Z | M_NEG | M_CY, 8'h80, E_CZ});
        st.push_back('{"c_undef7", NXT_COND, 8'h90, 3'd7, 0, 0, 0, 0, 16'h0, 8'h00, M_Z | M_NEG | M_CY, 8'h81, E_CZ});
        st.push_back('{"nxt_undef", 3'd7,    8'h90, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, 6'b0,  8'h82, E_CZ});
        st.push_back('{"jmp_ff",   NXT_JMP,  8'hFF, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, 6'b0,  8'hFF, E_CZ});
        st.push_back('{"seq_wrap", NXT_SEQ,  8'h00, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, 6'b0,  8'h00, E_CZ});
        st.push_back('{"c_ctrz_t", NXT_COND, 8'h33, COND_CTRZ, 0, 0, 0, 0, 16'h0, 8'h00, 6'b0,  8'h33, E_CZ});
        foreach (st[i]) begin
            drive(st[i]);
            sb.push_back(st[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({bus.upc, bus.halted, bus.irq_take, bus.ctr_zero} !== {e.e_upc, e.e_flg}) begin
                errors++;
                $display("FAIL %s: got upc=%h h/irq/cz=%b, want upc=%h h/irq/cz=%b",
                         e.nm, bus.upc, {bus.halted, bus.irq_take, bus.ctr_zero}, e.e_upc, e.e_flg);
            end
        end
    endtask

    task automatic test_halt();
        step_t st[$];
        step_t e;
        st.push_back('{"h_jmp05",   NXT_JMP,  8'h05, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, 6'b0,        8'h05, E_CZ});
        st.push_back('{"h_enter",   NXT_HALT, 8'h00, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, 6'b0,        8'h06, E_H | E_CZ});
        st.push_back('{"h_ignore",  NXT_DISP, 8'h00, COND_TRUE, 0, 0, 1, 0, 16'h9, 8'h40, M_SA | M_IE, 8'h06, E_H | E_CZ});
        st.push_back('{"h_exit",    NXT_SEQ,  8'h00, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, M_CONT,      8'h06, E_CZ});
        st.push_back('{"h_resume",  NXT_SEQ,  8'h00, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, 6'b0,        8'h07, E_CZ});
        st.push_back('{"h_cont_on", NXT_HALT, 8'h00, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, M_CONT,      8'h08, E_H | E_CZ});
        st.push_back('{"h_one_cyc", NXT_SEQ,  8'h00, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, M_CONT,      8'h08, E_CZ});
        st.push_back('{"h_run",     NXT_SEQ,  8'h00, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, 6'b0,        8'h09, E_CZ});
        foreach (st[i]) begin
            drive(st[i]);
            sb.push_back(st[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({bus.upc, bus.halted, bus.irq_take, bus.ctr_zero} !== {e.e_upc, e.e_flg}) begin
                errors++;
                $display("FAIL %s: got upc=%h h/irq/cz=%b, want upc=%h h/irq/cz=%b",
                         e.nm, bus.upc, {bus.halted, bus.irq_take, bus.ctr_zero}, e.e_upc, e.e_flg);
            end
        end
    endtask

    task automatic test_call();
        step_t st[$];
        step_t e;
        logic [7:0] ret1, ret2, ret3, hold;
`ifdef SCMP_USEQ_CALL_EN
        ret1 = 8'h13;
        ret2 = 8'hA1;
        ret3 = 8'hA2;
`else
        ret1 = 8'h00;
        ret2 = 8'h00;
        ret3 = 8'h00;
`endif
        hold = ret2;
        st.push_back('{"call_jmp12",  NXT_JMP,  8'h12, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, 6'b0, 8'h12, E_CZ});
        st.push_back('{"call_80",     NXT_CALL, 8'h80, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, 6'b0, 8'h80, E_CZ});
        st.push_back('{"call_body",   NXT_SEQ,  8'h00, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, 6'b0, 8'h81, E_CZ});
        st.push_back('{"ret_1",       NXT_RET,  8'h00, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, 6'b0, ret1,  E_CZ});
        st.push_back('{"call_a0",     NXT_CALL, 8'hA0, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, 6'b0, 8'hA0, E_CZ});
        st.push_back('{"call_nested", NXT_CALL, 8'hB0, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, 6'b0, 8'hB0, E_CZ});
        st.push_back('{"ret_nested",  NXT_RET,  8'h00, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, 6'b0, ret2,  E_CZ});
        st.push_back('{"call_stall",  NXT_CALL, 8'hC0, COND_TRUE, 1, 0, 0, 0, 16'h0, 8'h00, 6'b0, hold,  E_CZ});
        st.push_back('{"call_c0",     NXT_CALL, 8'hC0, COND_TRUE, 1, 1, 0, 0, 16'h0, 8'h00, 6'b0, 8'hC0, E_CZ});
        st.push_back('{"ret_3",       NXT_RET,  8'h00, COND_TRUE, 0, 0, 0, 0, 16'h0, 8'h00, 6'b0, ret3,  E_CZ});
        foreach (st[i]) begin
            drive(st[i]);
            sb.push_back(st[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks++;
            if ({bus.upc, bus.halted, bus.irq_take, bus.ctr_zero} !== {e.e_upc, e.e_flg}) begin
                errors++;
                $display("FAIL %s: got upc=%h h/irq/cz=%b, want upc=%h h/irq/cz=%b",
                         e.nm, bus.upc, {bus.halted, bus.irq_take, bus.ctr_zero}, e.e_upc, e.e_flg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dispatch();
        test_stall();
        test_counter();
        test_cond();
        test_halt();
        test_call();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
